// File: rtl/mic_frame_pkg.sv
// Shared types and constants for the microphone frame scheduler.
// No logic; MIC_SIGNED_EN selects offset-binary to two's-complement conversion in to_sample().
// No backpressure here; the scheduler stalls on held banks.
package mic_frame_pkg;

  localparam int DATA_W    = 12;
  localparam int FRAME_LEN = 64;
  localparam int ADDR_W    = $clog2(FRAME_LEN);
  localparam int NUM_CH    = 8;

  localparam logic [DATA_W-1:0] MIDSCALE = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    STALL = 2'd2
  } state_t;

  // Flipping the MSB of an offset-binary code is the same as subtracting midscale.
  function automatic logic [DATA_W-1:0] to_sample(input logic [DATA_W-1:0] raw);
`ifdef MIC_SIGNED_EN
    return raw ^ MIDSCALE;
`else
    return raw;
`endif
  endfunction

endpackage

// File: rtl/mic_frame_scheduler_tick.sv
// Sample-rate tick generator: one-cycle tick every SAMPLE_DIV cycles while enabled.
// Latency: tick asserts SAMPLE_DIV-1 cycles after enable rises; counter clears while disabled.
// No backpressure; ticks are free-running.
module sample_tick_gen #(
  parameter int SAMPLE_DIV = 6250
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = $clog2(SAMPLE_DIV + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLE_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLOCK) begin
    if (RESET || !enable) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/mic_frame_scheduler.sv
// Captures one ADC channel per sample tick into a ping-pong frame buffer and hands frames to the FFT loader.
// Latency: adc_data to buffer write 2 cycles; rd_data 1 cycle after rd_addr. MIC_SIGNED_EN stores two's-complement samples.
// Backpressure: a full bank waits for frame_ack; with both banks occupied, ticks are dropped and counted in overflow_cnt.
module mic_frame_scheduler
  import mic_frame_pkg::*;
#(
  parameter int SAMPLE_DIV = 6250,
  parameter int OVF_W      = 8
) (
  input  logic                   CLOCK,
  input  logic                   RESET,
  input  logic                   enable,
  input  logic [2:0]             ch_sel,
  input  logic [NUM_CH*DATA_W-1:0] adc_data,
  output logic                   frame_valid,
  input  logic                   frame_ack,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   sample_strobe,
  output logic [DATA_W-1:0]      sample_out,
  output logic [OVF_W-1:0]       overflow_cnt,
  output logic                   wr_bank
);

  logic                     tick;
  logic [NUM_CH*DATA_W-1:0] adc_q;
  state_t                   state;
  logic [ADDR_W-1:0]        idx;
  logic [2:0]               ch_lat;
  logic [1:0]               full;
  logic                     rd_bank;
  logic [DATA_W-1:0]        mem [2*FRAME_LEN];

  logic [2:0]        sel;
  logic [DATA_W-1:0] wr_val;
  logic              ack_evt;
  logic              other_free;
  logic              last_idx;
  logic              wr_en;

  sample_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
    .CLOCK  (CLOCK),
    .RESET  (RESET),
    .enable (enable),
    .tick   (tick)
  );

  always_ff @(posedge CLOCK) begin
    if (RESET) adc_q <= '0;
    else       adc_q <= adc_data;
  end

  // The first sample of a frame uses the live ch_sel so the latched channel covers the whole frame.
  assign sel        = (idx == '0) ? ch_sel : ch_lat;
  assign wr_val     = to_sample(adc_q[int'(sel)*DATA_W +: DATA_W]);
  assign ack_evt    = frame_ack && frame_valid;
  assign other_free = !full[~wr_bank] || (ack_evt && (rd_bank != wr_bank));
  assign last_idx   = (idx == ADDR_W'(FRAME_LEN - 1));
  assign wr_en      = !RESET && enable && (state == FILL) && tick;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state         <= IDLE;
      idx           <= '0;
      ch_lat        <= '0;
      full          <= '0;
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b0;
      frame_valid   <= 1'b0;
      sample_strobe <= 1'b0;
      sample_out    <= '0;
      overflow_cnt  <= '0;
    end else begin
      sample_strobe <= 1'b0;

      if (ack_evt) begin
        full[rd_bank] <= 1'b0;
        frame_valid   <= 1'b0;
      end else if (!frame_valid && (full != 2'b00)) begin
        frame_valid <= 1'b1;
        rd_bank     <= full[~rd_bank] ? ~rd_bank : rd_bank;
      end

      if (!enable) begin
        state <= IDLE;
        idx   <= '0;
      end else begin
        case (state)
          IDLE: begin
            idx <= '0;
            // A bank left full by an earlier stall must not be overwritten.
            if (!full[wr_bank]) begin
              state <= FILL;
            end else if (other_free) begin
              wr_bank <= ~wr_bank;
              state   <= FILL;
            end else begin
              state <= STALL;
            end
          end
          FILL: begin
            if (tick) begin
              sample_strobe <= 1'b1;
              sample_out    <= wr_val;
              if (idx == '0) ch_lat <= ch_sel;
              if (last_idx) begin
                full[wr_bank] <= 1'b1;
                idx           <= '0;
                if (other_free) wr_bank <= ~wr_bank;
                else            state   <= STALL;
              end else begin
                idx <= idx + 1'b1;
              end
            end
          end
          STALL: begin
            if (tick && (overflow_cnt != '1)) overflow_cnt <= overflow_cnt + 1'b1;
            if (other_free) begin
              wr_bank <= ~wr_bank;
              state   <= FILL;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (wr_en) mem[{wr_bank, idx}] <= wr_val;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) rd_data <= '0;
    else       rd_data <= mem[{rd_bank, rd_addr}];
  end

endmodule

// File: tb/tb_mic_frame_scheduler.sv
// Directed bench for mic_frame_scheduler with SAMPLE_DIV=4, FRAME_LEN=64, DATA_W=12.
module tb_mic_frame_scheduler;

`ifdef MIC_SIGNED_EN
  localparam logic [11:0] SMASK    = 12'h800;
  localparam logic [11:0] EXP_MID  = 12'h000;
  localparam logic [11:0] EXP_ZERO = 12'h800;
`else
  localparam logic [11:0] SMASK    = 12'h000;
  localparam logic [11:0] EXP_MID  = 12'h800;
  localparam logic [11:0] EXP_ZERO = 12'h000;
`endif

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        enable;
  logic [2:0]  ch_sel;
  logic [95:0] adc_data;
  logic        frame_valid;
  logic        frame_ack;
  logic [5:0]  rd_addr;
  logic [11:0] rd_data;
  logic        sample_strobe;
  logic [11:0] sample_out;
  logic [7:0]  overflow_cnt;
  logic        wr_bank;

  int checks   = 0;
  int failures = 0;
  int n        = 0;
  int m_idx    = 0;
  int done_cnt = 0;
  int strobes  = 0;
  int sb       = 0;

  logic [2:0]  m_ch;
  logic [95:0] hist [4];
  logic [11:0] cur_frame [64];
  logic [11:0] done_frames [8][64];
  logic        ch0_ovr_en;
  logic [11:0] ch0_ovr;

  mic_frame_scheduler #(.SAMPLE_DIV(4), .OVF_W(8)) dut (
    .CLOCK         (CLOCK),
    .RESET         (RESET),
    .enable        (enable),
    .ch_sel        (ch_sel),
    .adc_data      (adc_data),
    .frame_valid   (frame_valid),
    .frame_ack     (frame_ack),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .sample_strobe (sample_strobe),
    .sample_out    (sample_out),
    .overflow_cnt  (overflow_cnt),
    .wr_bank       (wr_bank)
  );

  always #5 CLOCK = ~CLOCK;

  function automatic logic [95:0] gen_adc(input int cyc);
    logic [95:0] v;
    for (int c = 0; c < 8; c++) v[c*12 +: 12] = 12'(cyc + c * 273);
    if (ch0_ovr_en) v[11:0] = ch0_ovr;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: observe 1 ns after the edge, score any written sample, then drive the next ADC word.
  task automatic step();
    logic [11:0] e;
    @(posedge CLOCK);
    #1;
    n++;
    if (sample_strobe === 1'b1) begin
      if (m_idx == 0) m_ch = ch_sel;
      e = hist[(n - 2) & 3][int'(m_ch)*12 +: 12] ^ SMASK;
      chk("sample_out", 32'(sample_out), 32'(e));
      cur_frame[m_idx] = e;
      m_idx++;
      strobes++;
      if (m_idx == 64) begin
        for (int k = 0; k < 64; k++) done_frames[done_cnt][k] = cur_frame[k];
        done_cnt++;
        m_idx = 0;
      end
    end
    adc_data = gen_adc(n);
    hist[n & 3] = adc_data;
  endtask

  task automatic wait_done(input int d, input int budget);
    int b = 0;
    while (done_cnt < d && b < budget) begin step(); b++; end
    chk("wait_frame_done", 32'(done_cnt >= d), 32'd1);
  endtask

  task automatic wait_idx(input int target, input int budget);
    int b = 0;
    while (m_idx != target && b < budget) begin step(); b++; end
    chk("wait_sample_idx", 32'(m_idx), 32'(target));
  endtask

  task automatic read_frame(input int f, input string tag);
    for (int k = 0; k < 64; k++) begin
      rd_addr = 6'(k);
      step();
      chk(tag, 32'(rd_data), 32'(done_frames[f][k]));
    end
  endtask

  task automatic do_ack();
    frame_ack = 1'b1;
    step();
    frame_ack = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_frame_valid"}, 32'(frame_valid), 32'd0);
    chk({tag, "_strobe"}, 32'(sample_strobe), 32'd0);
    chk({tag, "_sample_out"}, 32'(sample_out), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow_cnt), 32'd0);
    chk({tag, "_wr_bank"}, 32'(wr_bank), 32'd0);
    chk({tag, "_rd_data"}, 32'(rd_data), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET      = 1'b1;
    enable     = 1'b0;
    frame_ack  = 1'b0;
    ch_sel     = 3'd3;
    rd_addr    = '0;
    ch0_ovr_en = 1'b0;
    ch0_ovr    = '0;
    m_ch       = '0;
    adc_data   = gen_adc(0);
    hist[0]    = adc_data;

    repeat (3) step();
    chk_all_zero("reset");
    RESET = 1'b0;
    step();

    // Frame 0 on CH3: first write 4 cycles after enable, frame_valid one cycle after the 64th write.
    enable = 1'b1;
    repeat (3) step();
    chk("strobe_before_first_tick", 32'(sample_strobe), 32'd0);
    step();
    chk("first_strobe", 32'(sample_strobe), 32'd1);
    wait_done(1, 400);
    chk("fv_not_yet", 32'(frame_valid), 32'd0);
    step();
    chk("fv_frame0", 32'(frame_valid), 32'd1);
    chk("wr_bank_after_frame0", 32'(wr_bank), 32'd1);
    chk("overflow_frame0", 32'(overflow_cnt), 32'd0);
    step();
    do_ack();
    chk("fv_cleared_after_ack", 32'(frame_valid), 32'd0);
    read_frame(0, "rd_frame0");
    do_ack();
    chk("ack_while_idle_ignored", 32'(frame_valid), 32'd0);

    // Frames 1 and 2 with no consumer: bank 1 held, bank 0 fills, then STALL drops ticks.
    wait_done(2, 400);
    step();
    chk("fv_frame1", 32'(frame_valid), 32'd1);
    chk("wr_bank_frame2", 32'(wr_bank), 32'd0);
    wait_done(3, 400);
    chk("wr_bank_in_stall", 32'(wr_bank), 32'd0);
    sb = strobes;
    repeat (40) step();
    chk("overflow_10", 32'(overflow_cnt), 32'd10);
    chk("no_strobe_in_stall", 32'(strobes - sb), 32'd0);
    chk("fv_held_in_stall", 32'(frame_valid), 32'd1);
    read_frame(1, "rd_frame1");
    chk("overflow_26", 32'(overflow_cnt), 32'd26);
    ch_sel = 3'd2;
    do_ack();
    chk("fv_clear_stall_ack", 32'(frame_valid), 32'd0);
    chk("wr_bank_freed", 32'(wr_bank), 32'd1);
    step();
    chk("fv_reassert_frame2", 32'(frame_valid), 32'd1);
    chk("overflow_kept", 32'(overflow_cnt), 32'd26);
    step();
    step();
    chk("fill_resumes", 32'(sample_strobe), 32'd1);
    read_frame(2, "rd_frame2");
    do_ack();
    chk("fv_clear_frame2", 32'(frame_valid), 32'd0);

    // Frame 3: ch_sel 2 -> 5 after 30 samples; the model keeps CH2 for this frame.
    wait_idx(30, 400);
    ch_sel = 3'd5;
    wait_done(4, 400);
    step();
    chk("fv_frame3", 32'(frame_valid), 32'd1);
    chk("wr_bank_frame4", 32'(wr_bank), 32'd0);

    // Disable at sample 40: partial frame dropped, restart at index 0 in bank 0.
    wait_idx(40, 400);
    enable = 1'b0;
    m_idx  = 0;
    sb     = strobes;
    repeat (12) step();
    chk("no_strobe_disabled", 32'(strobes - sb), 32'd0);
    chk("fv_kept_disabled", 32'(frame_valid), 32'd1);
    chk("wr_bank_kept_disabled", 32'(wr_bank), 32'd0);
    enable = 1'b1;
    read_frame(3, "rd_frame3");

    // Ack lands in the same cycle as the last write of frame 4: no stall, no drop.
    wait_idx(63, 400);
    repeat (3) step();
    frame_ack = 1'b1;
    step();
    frame_ack = 1'b0;
    chk("last_sample_strobe", 32'(sample_strobe), 32'd1);
    chk("fv_clear_coincident", 32'(frame_valid), 32'd0);
    chk("wr_bank_coincident", 32'(wr_bank), 32'd1);
    chk("overflow_coincident", 32'(overflow_cnt), 32'd26);
    step();
    chk("fv_frame4", 32'(frame_valid), 32'd1);
    repeat (3) step();
    chk("no_stall_next_tick", 32'(sample_strobe), 32'd1);
    read_frame(4, "rd_frame4");

    // Reset in the middle of a frame, then CH0 midscale and zero codes.
    ch0_ovr_en = 1'b1;
    ch0_ovr    = 12'h800;
    RESET      = 1'b1;
    step();
    chk_all_zero("midframe_reset");
    m_idx = 0;
    step();
    RESET  = 1'b0;
    ch_sel = 3'd0;
    repeat (4) step();
    chk("mid_strobe", 32'(sample_strobe), 32'd1);
    chk("mid_code", 32'(sample_out), 32'(EXP_MID));
    ch0_ovr = 12'h000;
    repeat (4) step();
    chk("zero_strobe", 32'(sample_strobe), 32'd1);
    chk("zero_code", 32'(sample_out), 32'(EXP_ZERO));
    chk("overflow_after_reset", 32'(overflow_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mic_frame_scheduler.md
Name: mic_frame_scheduler

Overview:
- Sequences the 8-channel microphone ADC wrapper's continuously refreshed channel outputs into fixed-rate sample frames for the 64-point FFT.
- Generates the audio sample tick, captures one selected channel per tick, and fills a ping-pong buffer of FRAME_LEN samples.
- Hands completed frames to the FFT loader with a valid/ack handshake and counts dropped samples when the consumer falls behind.

Parameters:
- SAMPLE_DIV, 6250: CLOCK cycles per sample tick (50 MHz / 8 kHz).
- FRAME_LEN, 64: samples per frame; power of two, at least 4.
- DATA_W, 12: ADC sample width.
- OVF_W, 8: width of the dropped-sample counter.

Ports:
- CLOCK  in  1  system clock, same domain as the ADC wrapper outputs.
- RESET  in  1  synchronous, active-high reset.
- enable  in  1  run sampling; low returns the block to IDLE.
- ch_sel  in  3  channel to capture; latched at the first sample of each frame.
- adc_data  in  8*DATA_W  packed {CH7..CH0} from the ADC wrapper.
- frame_valid  out  1  a completed frame is held for the consumer.
- frame_ack  in  1  single-cycle pulse; consumer has finished with the held frame.
- rd_addr  in  log2(FRAME_LEN)  read index into the held frame.
- rd_data  out  DATA_W  sample at rd_addr; registered, 1-cycle latency.
- sample_strobe  out  1  one-cycle pulse each time a sample is written.
- sample_out  out  DATA_W  last written sample, valid with sample_strobe.
- overflow_cnt  out  OVF_W  saturating count of dropped ticks.
- wr_bank  out  1  bank currently being filled.

Behaviour:
- Reset values: all outputs 0, state IDLE, tick counter 0, both banks free, wr_bank 0, write index 0. Buffer contents are undefined.
- Tick: the counter runs only when enable=1. It produces a one-cycle tick when it reaches SAMPLE_DIV-1, then wraps to 0. The counter clears whenever enable=0.
- adc_data is registered once. The sample written on a tick is the registered value of the selected channel, giving 2-cycle latency from adc_data to the buffer write.
- States: IDLE, FILL, STALL.
  - IDLE to FILL when enable=1. The write index is 0.
  - FILL, on a tick:
    - Write the sample to wr_bank[idx] and pulse sample_strobe with sample_out in the same cycle as the write.
    - On idx=0, latch ch_sel for the frame.
    - On idx=FRAME_LEN-1: mark wr_bank full, set idx to 0, and switch to the other bank if it is free. If the other bank is still held, go to STALL.
  - STALL: every tick is dropped and increments overflow_cnt, saturating at all-ones. When the held bank is released, go to FILL on the next cycle using the freed bank.
  - Any state with enable=0: go to IDLE next cycle. The partial frame is discarded and idx is set to 0. Full or held banks remain valid.
- Handshake:
  - frame_valid rises the cycle after a bank becomes full, provided no bank is already held. That bank becomes the read bank.
  - frame_valid stays high until frame_ack, and clears the cycle after.
  - If the other bank is also full, it becomes the read bank and frame_valid reasserts one cycle later.
  - frame_ack while frame_valid=0 is ignored.
- Simultaneous events: if frame_ack and a frame completion occur in the same cycle, the ack is processed first. The completing frame takes the freed bank with no drop, and no STALL is entered.
- rd_data always reads the read bank, including while frame_valid is low; the value is meaningless then.
- overflow_cnt clears only on RESET.

Optional Feature:
- Macro MIC_SIGNED_EN.
- Defined: each sample is stored as a two's-complement value, equal to the raw sample XOR (1 << (DATA_W-1)), i.e. raw minus midscale 2048. sample_out and rd_data are signed.
- Undefined: the raw unsigned ADC code is stored.
- Timing and latency are identical in both cases.

Decomposition:
- Package mic_frame_pkg holds DATA_W, FRAME_LEN, ADDR_W = log2(FRAME_LEN), the state enum (IDLE/FILL/STALL) and the MIDSCALE constant.
- Sub-module sample_tick_gen contains the SAMPLE_DIV counter, with enable and tick ports.
- Buffer is inferred dual-port RAM of 2*FRAME_LEN words, addressed by {bank, idx}.

Test Plan:
- SAMPLE_DIV=4, ch_sel=3, CH3 ramps by 1 every cycle, frame_ack 2 cycles after frame_valid → frame_valid after 64 ticks; rd_data at addr k equals the CH3 value registered at tick k; overflow_cnt=0.
- Consumer never acks → first frame held, second bank fills, STALL entered, 10 further ticks → overflow_cnt=10; frame_ack → held frame released, frame_valid reasserts one cycle later for the second bank, FILL resumes.
- ch_sel changed from 2 to 5 at sample 30 → the rest of that frame is still CH2; the next frame is CH5.
- enable dropped at sample 40 → IDLE, no frame_valid; re-enable → the new frame starts at idx 0 in the same bank.
- frame_ack in the same cycle as the last sample of the next frame → no STALL, overflow_cnt unchanged, frame_valid high again 1 cycle after clearing.
- MIC_SIGNED_EN defined, CH0 = 0x800 → stored 0x000; CH0 = 0x000 → stored 0x800 (−2048); RESET asserted mid-frame → all outputs 0 on the next cycle.
